sequenciador_instrucoes: RTL and testbench



---
 rtl/sequenciador_instrucoes_if.sv | 29 ++
 rtl/sequenciador_instrucoes.sv | 138 +++++++++++++
 tb/tb_sequenciador_instrucoes.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sequenciador_instrucoes_if.sv
// Purpose: host/processor-facing signal bundle of the instruction sequencer.
// Latency: none; this file only groups wires.
// Backpressure: Done from the processor gates every issue; Run is a one-cycle strobe.
interface sequenciador_instrucoes_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  Start;
    logic                  Done;
    logic                  WrEn;
    logic [ADDR_WIDTH-1:0] WrAddr;
    logic [15:0]           WrData;
    logic [15:0]           DIN;
    logic                  Run;
    logic [ADDR_WIDTH-1:0] PC;
    logic                  Halted;
    logic                  Timeout;

    // sequencer side: drives the processor DIN/Run pair
    modport master (
        input  Start, Done, WrEn, WrAddr, WrData,
        output DIN, Run, PC, Halted, Timeout
    );

    // host/processor side
    modport slave (
        output Start, Done, WrEn, WrAddr, WrData,
        input  DIN, Run, PC, Halted, Timeout
    );
endinterface

// File: rtl/sequenciador_instrucoes.sv
// Purpose: program memory + PC feeding a multicycle processor, one instruction per Done.
// Latency: first Run one cycle after Start; next issue on the edge Done is sampled.
// Backpressure: waits indefinitely-bounded (watchdog) on Done; aborts to HALT with Timeout.
module sequenciador_instrucoes #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [2:0]  MVI_OPCODE = 3'b001,
    parameter logic [15:0] HALT_WORD  = 16'hFFFF,
    parameter int          TIMEOUT    = 16
) (
    input  logic                         i_Clock,
    input  logic                         i_Resetn,
    sequenciador_instrucoes_if.master    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_HALT} state_t;

    logic [15:0]           r_mem [DEPTH];
    state_t                r_state;
    logic [15:0]           r_din;
    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [WD_W-1:0]       r_wd;
    logic                  r_timeout;

    state_t                w_state_n;
    logic [15:0]           w_din_n;
    logic                  w_run_n;
    logic [ADDR_WIDTH-1:0] w_pc_n;
    logic [WD_W-1:0]       w_wd_n;
    logic                  w_timeout_n;
    logic                  w_dispatch;
    logic                  w_stopped;
    logic [ADDR_WIDTH-1:0] w_disp_addr;
    logic [15:0]           w_disp_word;
    logic                  w_halted;
    logic                  w_wr_ok;

    // A (re)start always dispatches from address 0, otherwise from the current PC.
    assign w_stopped   = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_disp_addr = w_stopped ? '0 : r_pc;
    assign w_disp_word = r_mem[w_disp_addr];

    // State and datapath registers; memory is deliberately outside the reset domain.
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_state   <= S_IDLE;
            r_din     <= 16'h0000;
            r_run     <= 1'b0;
            r_pc      <= '0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_din     <= w_din_n;
            r_run     <= w_run_n;
            r_pc      <= w_pc_n;
            r_wd      <= w_wd_n;
            r_timeout <= w_timeout_n;
        end
    end

    // Program memory write port, only open while execution is stopped.
    always_ff @(posedge i_Clock) begin
        if (w_wr_ok) begin
            r_mem[bus.WrAddr] <= bus.WrData;
        end
    end

    // Next-state and datapath: sequencing, immediate fetch, watchdog, shared dispatch.
    always_comb begin
        w_state_n   = r_state;
        w_din_n     = r_din;
        w_run_n     = 1'b0;
        w_pc_n      = r_pc;
        w_wd_n      = r_wd;
        w_timeout_n = r_timeout;
        w_dispatch  = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.Start) begin
                    w_timeout_n = 1'b0;
                    w_dispatch  = 1'b1;
                end
            end
            S_ISSUE: begin
                w_wd_n = '0;
                if (r_din[8:6] == MVI_OPCODE) begin
                    // immediate lands on DIN for the processor's T1 step
                    w_din_n   = r_mem[r_pc];
                    w_pc_n    = r_pc + PC_ONE;
                    w_state_n = S_IMM;
                end else begin
                    w_state_n = S_WAIT;
                end
            end
            S_IMM, S_WAIT: begin
                if (bus.Done) begin
                    // Done takes priority over a watchdog expiry on the same edge
                    w_dispatch = 1'b1;
                end else begin
                    w_wd_n = r_wd + WD_W'(1);
                    if (w_wd_n == WD_LAST) begin
                        w_timeout_n = 1'b1;
                        w_state_n   = S_HALT;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_dispatch) begin
            w_pc_n = w_disp_addr;
            if (w_disp_word == HALT_WORD) begin
                w_state_n = S_HALT;
            end else begin
                w_din_n   = w_disp_word;
                w_run_n   = 1'b1;
                w_pc_n    = w_disp_addr + PC_ONE;
                w_state_n = S_ISSUE;
            end
        end
    end

    // Outputs decoded from state.
    always_comb begin
        w_halted = (r_state == S_HALT);
        w_wr_ok  = bus.WrEn && w_stopped;
    end

    assign bus.DIN     = r_din;
    assign bus.Run     = r_run;
    assign bus.PC      = r_pc;
    assign bus.Halted  = w_halted;
    assign bus.Timeout = r_timeout;
endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Purpose: directed self-checking bench for the instruction sequencer.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: Done is driven by hand to emulate the processor.
module tb_sequenciador_instrucoes;
    logic clk = 1'b0;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;
    int   run_cnt = 0;

    always #5 clk = ~clk;

    sequenciador_instrucoes_if #(.ADDR_WIDTH(5)) u_if ();
    sequenciador_instrucoes_if #(.ADDR_WIDTH(2)) u_if2 ();

    sequenciador_instrucoes #(
        .ADDR_WIDTH(5), .MVI_OPCODE(3'b001), .HALT_WORD(16'hFFFF), .TIMEOUT(16)
    ) u_dut (
        .i_Clock(clk), .i_Resetn(rstn), .bus(u_if.master)
    );

    sequenciador_instrucoes #(
        .ADDR_WIDTH(2), .MVI_OPCODE(3'b001), .HALT_WORD(16'hFFFF), .TIMEOUT(16)
    ) u_dut2 (
        .i_Clock(clk), .i_Resetn(rstn), .bus(u_if2.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (u_if.Run) run_cnt++;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        u_if.WrEn = 1'b1; u_if.WrAddr = a; u_if.WrData = d;
        step();
        u_if.WrEn = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] a, input logic [15:0] d);
        u_if2.WrEn = 1'b1; u_if2.WrAddr = a; u_if2.WrData = d;
        step();
        u_if2.WrEn = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_din"},     u_if.DIN,     16'h0000);
        chk({tag, "_run"},     u_if.Run,     1'b0);
        chk({tag, "_pc"},      u_if.PC,      5'd0);
        chk({tag, "_halted"},  u_if.Halted,  1'b0);
        chk({tag, "_timeout"}, u_if.Timeout, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        u_if.Start = 0;  u_if.Done = 0;  u_if.WrEn = 0;  u_if.WrAddr = '0;  u_if.WrData = '0;
        u_if2.Start = 0; u_if2.Done = 0; u_if2.WrEn = 0; u_if2.WrAddr = '0; u_if2.WrData = '0;
        step();
        chk_reset("rst");
        rstn = 1'b1;
        step();

        // mvi followed by halt
        wr(0, 16'h0040); wr(1, 16'h0005); wr(2, 16'hFFFF);
        u_if.Start = 1; step(); u_if.Start = 0;
        chk("mvi_run", u_if.Run, 1'b1);
        chk("mvi_din", u_if.DIN, 16'h0040);
        chk("mvi_pc",  u_if.PC,  5'd1);
        step();
        chk("imm_din", u_if.DIN, 16'h0005);
        chk("imm_run", u_if.Run, 1'b0);
        chk("imm_pc",  u_if.PC,  5'd2);
        u_if.Done = 1; step(); u_if.Done = 0;
        chk("mvi_halted", u_if.Halted, 1'b1);
        chk("mvi_halt_pc", u_if.PC, 5'd2);
        chk("mvi_halt_run", u_if.Run, 1'b0);

        // two plain instructions with slow Done, plus a write attempt in WAIT
        wr(0, 16'h000A); wr(1, 16'h0011); wr(2, 16'hFFFF); wr(5, 16'h0022); wr(6, 16'hFFFF);
        run_cnt = 0;
        u_if.Start = 1; step(); u_if.Start = 0;
        chk("seq_din0", u_if.DIN, 16'h000A);
        step();
        u_if.WrEn = 1; u_if.WrAddr = 5'd5; u_if.WrData = 16'hBEEF;
        step();
        u_if.WrEn = 0;
        step(); step();
        chk("seq_hold0", u_if.DIN, 16'h000A);
        chk("seq_norun0", u_if.Run, 1'b0);
        u_if.Done = 1; step(); u_if.Done = 0;
        chk("seq_din1", u_if.DIN, 16'h0011);
        chk("seq_run1", u_if.Run, 1'b1);
        step(); step(); step(); step();
        chk("seq_hold1", u_if.DIN, 16'h0011);
        u_if.Done = 1; step(); u_if.Done = 0;
        chk("seq_halted", u_if.Halted, 1'b1);
        chk("seq_runs", run_cnt, 2);

        // read mem[5] back by executing up to it
        for (int i = 0; i < 5; i++) wr(5'(i), 16'h0000);
        u_if.Done = 1; u_if.Start = 1; step(); u_if.Start = 0;
        for (int k = 0; k < 30 && !u_if.Halted; k++) step();
        u_if.Done = 0;
        chk("rb_halted", u_if.Halted, 1'b1);
        chk("rb_mem5", u_if.DIN, 16'h0022);
        chk("rb_pc", u_if.PC, 5'd6);

        // watchdog expiry
        wr(0, 16'h000A); wr(1, 16'hFFFF);
        u_if.Start = 1; step(); u_if.Start = 0;
        chk("wd_run", u_if.Run, 1'b1);
        repeat (15) step();
        chk("wd_early_to", u_if.Timeout, 1'b0);
        chk("wd_early_halt", u_if.Halted, 1'b0);
        step();
        chk("wd_timeout", u_if.Timeout, 1'b1);
        chk("wd_halted", u_if.Halted, 1'b1);
        u_if.Start = 1; step(); u_if.Start = 0;
        chk("wd_clr_to", u_if.Timeout, 1'b0);
        chk("wd_clr_halt", u_if.Halted, 1'b0);
        chk("wd_rerun", u_if.Run, 1'b1);
        chk("wd_rerun_din", u_if.DIN, 16'h000A);
        u_if.Done = 1; step(); step(); u_if.Done = 0;
        chk("wd_rerun_halt", u_if.Halted, 1'b1);

        // Done on the expiry edge wins
        wr(1, 16'h0011); wr(2, 16'hFFFF);
        u_if.Start = 1; step(); u_if.Start = 0;
        repeat (15) step();
        u_if.Done = 1; step(); u_if.Done = 0;
        chk("race_to", u_if.Timeout, 1'b0);
        chk("race_run", u_if.Run, 1'b1);
        chk("race_din", u_if.DIN, 16'h0011);
        u_if.Done = 1; step(); step(); u_if.Done = 0;
        chk("race_halt", u_if.Halted, 1'b1);

        // mvi at the last address takes its immediate from address 0
        wr2(0, 16'h1234); wr2(1, 16'h0000); wr2(2, 16'h0000); wr2(3, 16'h0040);
        u_if2.Done = 1; u_if2.Start = 1; step(); u_if2.Start = 0;
        repeat (5) step();
        step();
        chk("wrap_din", u_if2.DIN, 16'h0040);
        chk("wrap_run", u_if2.Run, 1'b1);
        chk("wrap_pc",  u_if2.PC,  2'd0);
        step();
        chk("wrap_imm", u_if2.DIN, 16'h1234);
        chk("wrap_pc1", u_if2.PC,  2'd1);
        u_if2.Done = 0;

        // asynchronous reset during IMM, program retained
        wr(0, 16'h0040); wr(1, 16'h0005); wr(2, 16'hFFFF);
        u_if.Start = 1; step(); u_if.Start = 0;
        step();
        chk("ar_imm", u_if.DIN, 16'h0005);
        #2 rstn = 1'b0;
        #1 chk_reset("ar");
        step();
        rstn = 1'b1;
        u_if.Start = 1; step(); u_if.Start = 0;
        chk("ar_din", u_if.DIN, 16'h0040);
        chk("ar_run", u_if.Run, 1'b1);
        step();
        chk("ar_imm2", u_if.DIN, 16'h0005);
        u_if.Done = 1; step(); u_if.Done = 0;
        chk("ar_halt", u_if.Halted, 1'b1);
        chk("ar_pc", u_if.PC, 5'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
